regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port integer register file with a built-in write-back
//  scoreboard for the pipelined core. It sits in the decode stage. Decode reads
//  operands and reserves its destination register at issue. Write-back writes
//  the result and releases the reservation. Operands read during write-back can
//  be bypassed, and a WAW stall handshake is provided.
// PARAMETERS
//  XLEN    32  data width of each register
//  NREG    32  number of architectural registers (power of 2, >=2); x0 is hardwired 0
//  NRD     2   number of asynchronous read ports (1..4)
//  BYPASS  1   1: same-cycle write-back data is forwarded to reads; 0: no forwarding
// PORTS
//  clk          in   1            clock; all state updates on posedge
//  reset        in   1            synchronous, active-high
//  rs_addr      in   NRD*AW       read addresses, port i at [i*AW +: AW]; AW=$clog2(NREG)
//  rs_data      out  NRD*XLEN     read data, port i at [i*XLEN +: XLEN]
//  rs_busy      out  NRD          port i operand has an outstanding reservation (not yet valid)
//  issue_valid  in   1            decode requests a reservation of issue_rd
//  issue_rd     in   AW           destination register to reserve
//  issue_ready  out  1            reservation accepted this cycle if issue_valid & issue_ready
//  wb_valid     in   1            write-back strobe
//  wb_rd        in   AW           write-back destination
//  wb_data      in   XLEN         write-back data
//  flush        in   1            drop all reservations (pipeline squash); data is kept
//  pend_cnt     out  $clog2(NREG)+1  number of registers currently reserved
// BEHAVIOUR
//  - Reset (synchronous): all registers set to 0, pending[] set to 0, and pend_cnt set to 0.
//    Because the reads are combinational, rs_data=0, rs_busy=0 and issue_ready=1 in
//    the cycle after reset. A reset mid-operation discards in-flight wb and issue requests.
//  - Read (combinational, 0 latency): rs_addr==0 gives rs_data=0 and rs_busy=0.
//    BYPASS=1 with wb_valid and wb_rd==rs_addr!=0 gives rs_data=wb_data and rs_busy=0.
//    Otherwise rs_data=reg[addr] and rs_busy=pending[addr].
//  - Write: on posedge, if wb_valid && wb_rd!=0, then reg[wb_rd]<=wb_data and pending[wb_rd]<=0.
//    Writing x0 is ignored and never reserves.
//  - Issue: issue_ready = !(pending[issue_rd]) || issue_rd==0 || (wb_valid && wb_rd==issue_rd).
//    A pending reservation on the same register stalls issue to prevent WAW.
//    On accept with issue_rd!=0, pending[issue_rd]<=1.
//  - Simultaneous wb and issue to the same rd: the data is written and pending ends up 1,
//    because the new producer wins.
//  - flush: pending[]<=0 on posedge. flush takes priority over an issue in the same cycle,
//    so that issue is not reserved. A wb in the same cycle still writes data.
//  - pend_cnt = popcount(pending), held as a registered counter.
//    Update: +1 on accepted issue to a non-pending register, -1 on wb to a pending register,
//    net 0 when both apply. flush sets it to 0. Range 0..NREG-1; it can never wrap.
//  - wb to a non-pending register is legal: data is written and pend_cnt is unchanged.
//  - The register array is updated on posedge only; there are no negedge writes.
// STRUCTURE
//  - Package rf_pkg: localparam function addr_w(nreg), typedef reg_addr_t / xdata_t
//    (driven by XLEN/NREG defaults), and constant REG_ZERO = '0.
//  - Sub-module rf_scoreboard: holds pending[NREG], pend_cnt, issue_ready and the
//    flush/priority logic. The top level holds the data array, read muxes and bypass.
//  - The read ports are built with a generate loop over NRD.
// TESTING
//  1 Reset: write x5=0xDEAD, then assert reset for one cycle -> read x5 = 0, pend_cnt = 0,
//    issue_ready = 1.
//  2 x0: wb x0=0xFFFF_FFFF, issue x0 -> read x0 = 0, rs_busy = 0, pend_cnt = 0.
//  3 Scoreboard: issue x3 -> rs_busy(x3) = 1 and pend_cnt = 1. Then issue x3 again ->
//    issue_ready = 0. Then wb x3=0x1234 -> next cycle busy = 0, data = 0x1234, pend_cnt = 0.
//  4 Bypass: BYPASS=1, x7 pending, wb x7=0xCAFE with rs_addr[1]=7 in the same cycle ->
//    rs_data[1] = 0xCAFE, busy = 0. With BYPASS=0 -> old value and busy = 1.
//  5 Collisions: same-cycle wb x9=0x55 + issue x9 -> x9 = 0x55, pending = 1, pend_cnt unchanged.
//    flush + issue x4 -> pend_cnt = 0 and x4 not busy.
//  6 Params: NREG=16, NRD=3, XLEN=64 -> write and read all 15 registers on all 3 ports.
//    Fill 15 reservations -> pend_cnt = 15.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared types and helpers for the register file and its scoreboard.
// Address width is derived from the register count.
package rf_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;

  function automatic int addr_w(int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

  typedef logic [addr_w(NREG_D)-1:0] reg_addr_t;
  typedef logic [XLEN_D-1:0]         xdata_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back bundle for the register file.
// master = decode/wb side, slave = register file.
interface regfile_sb_if
  import rf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = addr_w(NREG);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic [AW:0]         pend_cnt;

  modport master (
    output rs_addr, issue_valid, issue_rd,
    output wb_valid, wb_rd, wb_data, flush,
    input  rs_data, rs_busy, issue_ready, pend_cnt
  );

  modport slave (
    input  rs_addr, issue_valid, issue_rd,
    input  wb_valid, wb_rd, wb_data, flush,
    output rs_data, rs_busy, issue_ready, pend_cnt
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Write-back scoreboard: pending bits, reservation count
// and the WAW issue stall.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = 32,
  localparam int AW = addr_w(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pend_cnt
);

  logic [NREG-1:0] pend_q;
  logic [AW:0]     cnt_q;
  logic            wb_clr;
  logic            same;
  logic            accept;
  logic            inc;
  logic            dec;

  assign wb_clr = wb_valid && (wb_rd != '0);
  assign same   = wb_clr && (wb_rd == issue_rd);

  assign issue_ready = (issue_rd == '0)
                    || !pend_q[issue_rd]
                    || (wb_valid && (wb_rd == issue_rd));

  assign accept = issue_valid && issue_ready
               && (issue_rd != '0) && !flush;

  // a reservation freed by a same-cycle wb still counts as a new one
  assign inc = accept && (!pend_q[issue_rd] || same);
  assign dec = wb_clr && pend_q[wb_rd];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wb_clr) pend_q[wb_rd] <= 1'b0;
      if (accept) pend_q[issue_rd] <= 1'b1;
      if (inc && !dec) cnt_q <= cnt_q + 1'b1;
      if (dec && !inc) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign pending  = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write-back scoreboard
// and optional same-cycle write-back forwarding.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic reset,
  regfile_sb_if.slave bus
);

  localparam int AW = addr_w(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;

  rf_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(bus.issue_valid),
    .issue_rd   (bus.issue_rd),
    .issue_ready(bus.issue_ready),
    .wb_valid   (bus.wb_valid),
    .wb_rd      (bus.wb_rd),
    .flush      (bus.flush),
    .pending    (pending),
    .pend_cnt   (bus.pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.wb_valid && bus.wb_rd != '0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] d;
    logic            b;

    assign a   = bus.rs_addr[g*AW +: AW];
    assign hit = (BYPASS != 0) && bus.wb_valid
              && (a != '0) && (bus.wb_rd == a);

    always_comb begin
      d = regs[a];
      b = pending[a];
      unique case (1'b1)
        (a == '0): begin
          d = '0;
          b = 1'b0;
        end
        hit: begin
          d = bus.wb_data;
          b = 1'b0;
        end
        default: ;
      endcase
    end

    assign bus.rs_data[g*XLEN +: XLEN] = d;
    assign bus.rs_busy[g]              = b;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass
// and 16x64 three-port configurations.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_sb_if mi ();
  regfile_sb_if ni ();
  regfile_sb_if #(.XLEN(64), .NREG(16), .NRD(3)) bi ();

  regfile_sb u_main (
    .clk  (clk),
    .reset(reset),
    .bus  (mi)
  );

  regfile_sb #(.BYPASS(0)) u_nb (
    .clk  (clk),
    .reset(reset),
    .bus  (ni)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_big (
    .clk  (clk),
    .reset(reset),
    .bus  (bi)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mi.rs_addr = '0; mi.issue_valid = 0; mi.issue_rd = '0;
    mi.wb_valid = 0; mi.wb_rd = '0; mi.wb_data = '0;
    mi.flush = 0;
    ni.rs_addr = '0; ni.issue_valid = 0; ni.issue_rd = '0;
    ni.wb_valid = 0; ni.wb_rd = '0; ni.wb_data = '0;
    ni.flush = 0;
    bi.rs_addr = '0; bi.issue_valid = 0; bi.issue_rd = '0;
    bi.wb_valid = 0; bi.wb_rd = '0; bi.wb_data = '0;
    bi.flush = 0;
    step();
    step();
    reset = 0;

    // 1: reset clears data and scoreboard
    mi.wb_valid = 1; mi.wb_rd = 5; mi.wb_data = 32'hDEAD;
    mi.issue_valid = 1; mi.issue_rd = 6;
    step();
    mi.wb_valid = 0; mi.issue_valid = 0;
    mi.rs_addr[4:0] = 5;
    #1;
    check("x5_written", 64'(mi.rs_data[31:0]), 64'hDEAD);
    check("cnt_pre_rst", 64'(mi.pend_cnt), 64'd1);
    reset = 1;
    step();
    reset = 0;
    mi.issue_rd = 6;
    #1;
    check("rst_x5", 64'(mi.rs_data[31:0]), 64'h0);
    check("rst_cnt", 64'(mi.pend_cnt), 64'd0);
    check("rst_ready", 64'(mi.issue_ready), 64'd1);

    // 2: x0 never written, never reserved
    mi.wb_valid = 1; mi.wb_rd = 0; mi.wb_data = 32'hFFFF_FFFF;
    mi.issue_valid = 1; mi.issue_rd = 0;
    step();
    mi.wb_valid = 0; mi.issue_valid = 0;
    mi.rs_addr[4:0] = 0;
    #1;
    check("x0_data", 64'(mi.rs_data[31:0]), 64'h0);
    check("x0_busy", 64'(mi.rs_busy[0]), 64'd0);
    check("x0_cnt", 64'(mi.pend_cnt), 64'd0);

    // 3: reserve, WAW stall, release
    mi.issue_valid = 1; mi.issue_rd = 3;
    step();
    mi.issue_valid = 0;
    mi.rs_addr[4:0] = 3;
    #1;
    check("x3_busy", 64'(mi.rs_busy[0]), 64'd1);
    check("x3_cnt", 64'(mi.pend_cnt), 64'd1);
    mi.issue_valid = 1;
    #1;
    check("x3_stall", 64'(mi.issue_ready), 64'd0);
    step();
    check("x3_cnt_hold", 64'(mi.pend_cnt), 64'd1);
    mi.issue_valid = 0;
    mi.wb_valid = 1; mi.wb_rd = 3; mi.wb_data = 32'h1234;
    step();
    mi.wb_valid = 0;
    #1;
    check("x3_free", 64'(mi.rs_busy[0]), 64'd0);
    check("x3_data", 64'(mi.rs_data[31:0]), 64'h1234);
    check("x3_cnt0", 64'(mi.pend_cnt), 64'd0);

    // 4: bypass on the main instance
    mi.issue_valid = 1; mi.issue_rd = 7;
    step();
    mi.issue_valid = 0;
    mi.wb_valid = 1; mi.wb_rd = 7; mi.wb_data = 32'hCAFE;
    mi.rs_addr[9:5] = 7;
    #1;
    check("byp_data", 64'(mi.rs_data[63:32]), 64'hCAFE);
    check("byp_busy", 64'(mi.rs_busy[1]), 64'd0);
    step();
    mi.wb_valid = 0;
    #1;
    check("byp_cnt", 64'(mi.pend_cnt), 64'd0);

    // 4b: no forwarding when BYPASS=0
    ni.wb_valid = 1; ni.wb_rd = 7; ni.wb_data = 32'h1111;
    step();
    ni.wb_valid = 0;
    ni.issue_valid = 1; ni.issue_rd = 7;
    step();
    ni.issue_valid = 0;
    ni.wb_valid = 1; ni.wb_rd = 7; ni.wb_data = 32'hCAFE;
    ni.rs_addr[9:5] = 7;
    #1;
    check("nb_data", 64'(ni.rs_data[63:32]), 64'h1111);
    check("nb_busy", 64'(ni.rs_busy[1]), 64'd1);
    step();
    ni.wb_valid = 0;
    #1;
    check("nb_after", 64'(ni.rs_data[63:32]), 64'hCAFE);

    // 5: wb + issue on same rd, then flush + issue
    mi.issue_valid = 1; mi.issue_rd = 9;
    step();
    mi.wb_valid = 1; mi.wb_rd = 9; mi.wb_data = 32'h55;
    #1;
    check("coll_ready", 64'(mi.issue_ready), 64'd1);
    step();
    mi.wb_valid = 0; mi.issue_valid = 0;
    mi.rs_addr[4:0] = 9;
    #1;
    check("coll_data", 64'(mi.rs_data[31:0]), 64'h55);
    check("coll_busy", 64'(mi.rs_busy[0]), 64'd1);
    check("coll_cnt", 64'(mi.pend_cnt), 64'd1);
    mi.flush = 1;
    mi.issue_valid = 1; mi.issue_rd = 4;
    mi.wb_valid = 1; mi.wb_rd = 10; mi.wb_data = 32'hABC;
    step();
    mi.flush = 0; mi.issue_valid = 0; mi.wb_valid = 0;
    mi.rs_addr[4:0] = 4; mi.rs_addr[9:5] = 9;
    #1;
    check("fl_cnt", 64'(mi.pend_cnt), 64'd0);
    check("fl_x4", 64'(mi.rs_busy[0]), 64'd0);
    check("fl_x9", 64'(mi.rs_busy[1]), 64'd0);
    mi.rs_addr[4:0] = 10;
    #1;
    check("fl_wb", 64'(mi.rs_data[31:0]), 64'hABC);
    mi.wb_valid = 1; mi.wb_rd = 11; mi.wb_data = 32'h77;
    step();
    mi.wb_valid = 0;
    check("np_wb_cnt", 64'(mi.pend_cnt), 64'd0);

    // 6: 16 x 64-bit, 3 ports
    for (int r = 1; r < 16; r++) begin
      bi.wb_valid = 1;
      bi.wb_rd = 4'(r);
      bi.wb_data = 64'hF00D_0000_0000_0000
                 + 64'(r) * 64'h1_0000_0001;
      step();
    end
    bi.wb_valid = 0;
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 3; p++) bi.rs_addr[p*4 +: 4] = 4'(r);
      #1;
      for (int p = 0; p < 3; p++) begin
        check($sformatf("big_r%0d_p%0d", r, p),
              bi.rs_data[p*64 +: 64],
              (r == 0) ? 64'h0
                       : 64'hF00D_0000_0000_0000
                         + 64'(r) * 64'h1_0000_0001);
      end
    end
    for (int r = 1; r < 16; r++) begin
      bi.issue_valid = 1;
      bi.issue_rd = 4'(r);
      step();
    end
    bi.issue_valid = 0;
    bi.issue_rd = 3;
    #1;
    check("big_cnt15", 64'(bi.pend_cnt), 64'd15);
    check("big_stall", 64'(bi.issue_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
